xor_result_buffer: RTL and testbench

- Downstream stage of the 4-bit registered XOR datapath: captures each result word `y` when the producer flags it valid.
- Buffers words in a small FIFO and hands them to a consumer over a valid/ready handshake.
- Keeps push/pop statistics and a sticky overflow flag, so benches and the checker can read throughput and loss without monitoring every cycle.

---
 rtl/xor_result_buffer.sv | 176 +++++++++++++++++
 tb/tb_xor_result_buffer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/xor_result_buffer.sv
//-----------------------------------------------------------------------------
// xor_result_buffer
//
// Sits after the 4-bit registered XOR datapath. It captures each result word
// that the producer marks valid, keeps the words in a small first-word
// fall-through FIFO, and hands them to a consumer over a valid/ready
// handshake. It also keeps push/pop statistics and a sticky overflow flag, so
// throughput and loss can be read at any time without watching every cycle.
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   asynchronous, active-high; clears all state at once
//   in_valid    in   producer offers in_data this cycle
//   in_data     in   result word (DATA_W)
//   in_ready    out  buffer can accept a word (not full)
//   out_valid   out  out_data holds the oldest stored word (not empty)
//   out_data    out  oldest stored word, 0 when empty (DATA_W)
//   out_ready   in   consumer takes out_data this cycle
//   level       out  number of stored words, 0..DEPTH
//   overflow    out  sticky: a word was offered while the buffer was full
//   push_count  out  accepted words, saturating (CNT_W)
//   pop_count   out  delivered words, saturating (CNT_W)
//
// Parameters
//   DATA_W  word width
//   DEPTH   number of entries; must be a power of two and at least 2 so the
//           pointers wrap naturally at their own width
//   CNT_W   width of the statistics counters
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module xor_result_buffer #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         push_count,
    output logic [CNT_W-1:0]         pop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_EMPTY = '0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    //-------------------------------------------------------------------------
    // State
    //-------------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [LVL_W-1:0]  level_q,      level_d;
    logic              overflow_q,   overflow_d;
    logic [CNT_W-1:0]  push_count_q, push_count_d;
    logic [CNT_W-1:0]  pop_count_q,  pop_count_d;

    //-------------------------------------------------------------------------
    // Handshake qualifiers
    //-------------------------------------------------------------------------
    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == LVL_EMPTY);

    // in_ready is deliberately independent of out_ready: a word offered to a
    // full buffer is refused even if the consumer frees a slot on the same
    // edge. This keeps in_ready a pure register decode with no
    // consumer-to-producer combinational path.
    assign push = in_valid && !full;
    assign pop  = out_ready && !empty;

    //-------------------------------------------------------------------------
    // Next-state logic
    //-------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        push_count_d = push_count_q;
        pop_count_d  = pop_count_q;

        // Pointers are exactly PTR_W bits wide, so +1 wraps modulo DEPTH.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // Simultaneous push and pop leaves the level unchanged.
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Sticky until reset; the refused word is simply not written.
        if (in_valid && full) begin
            overflow_d = 1'b1;
        end

        // Statistics counters hold at all-ones instead of wrapping, so a
        // saturated value is recognisable as "at least this many".
        if (push && (push_count_q != CNT_MAX)) begin
            push_count_d = push_count_q + 1'b1;
        end
        if (pop && (pop_count_q != CNT_MAX)) begin
            pop_count_d = pop_count_q + 1'b1;
        end
    end

    //-------------------------------------------------------------------------
    // Control registers (asynchronous reset)
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            push_count_q <= '0;
            pop_count_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            push_count_q <= push_count_d;
            pop_count_q  <= pop_count_d;
        end
    end

    //-------------------------------------------------------------------------
    // Storage
    //
    // The array has no reset: clearing level and the pointers discards its
    // contents, and out_data is gated to 0 whenever the buffer is empty, so
    // stale words can never be observed. Leaving it unreset lets it map onto
    // distributed RAM. The read is asynchronous so the head word falls
    // through one cycle after it is accepted.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    //-------------------------------------------------------------------------
    // Outputs
    //-------------------------------------------------------------------------
    assign in_ready   = !full;
    assign out_valid  = !empty;
    assign out_data   = empty ? '0 : mem_q[rd_ptr_q];
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign push_count = push_count_q;
    assign pop_count  = pop_count_q;

endmodule

// File: tb/tb_xor_result_buffer.sv
//-----------------------------------------------------------------------------
// tb_xor_result_buffer
//
// Directed bench for xor_result_buffer. Each step drives the inputs, checks
// every output against a reference scoreboard on the falling edge, then
// advances the reference across the rising edge. Accepted words are pushed
// to a queue as stimulus is driven; the head of the queue is the required
// out_data and is popped when the consumer takes a word.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_xor_result_buffer;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic [CNT_W-1:0]  push_count;
    logic [CNT_W-1:0]  pop_count;

    xor_result_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .level      (level),
        .overflow   (overflow),
        .push_count (push_count),
        .pop_count  (pop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic [DATA_W-1:0] sb[$];
    int                m_level;
    bit                m_ovf;
    int                m_push;
    int                m_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_level = 0;
        m_ovf   = 1'b0;
        m_push  = 0;
        m_pop   = 0;
    endtask

    task automatic check_outputs(input string ctx);
        logic [DATA_W-1:0] exp_data;
        exp_data = (sb.size() > 0) ? sb[0] : '0;
        chk({ctx, ".in_ready"},   32'(in_ready),   32'(m_level != DEPTH));
        chk({ctx, ".out_valid"},  32'(out_valid),  32'(m_level != 0));
        chk({ctx, ".out_data"},   32'(out_data),   32'(exp_data));
        chk({ctx, ".level"},      32'(level),      32'(m_level));
        chk({ctx, ".overflow"},   32'(overflow),   32'(m_ovf));
        chk({ctx, ".push_count"}, 32'(push_count), 32'(m_push));
        chk({ctx, ".pop_count"},  32'(pop_count),  32'(m_pop));
    endtask

    // One clock cycle: drive, check on the falling edge, advance the
    // reference across the rising edge.
    task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit r, input string ctx);
        bit do_push;
        bit do_pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
        check_outputs(ctx);
        do_push = v && (m_level != DEPTH);
        do_pop  = r && (m_level != 0);
        @(posedge clk);
        if (v && (m_level == DEPTH)) m_ovf = 1'b1;
        if (do_pop) begin
            void'(sb.pop_front());
            m_pop++;
        end
        if (do_push) begin
            sb.push_back(d);
            m_push++;
        end
        m_level = m_level + int'(do_push) - int'(do_pop);
        $display("[%0t] %s v=%0b d=%h r=%0b push=%0b pop=%0b level=%0d",
                 $time, ctx, v, d, r, do_push, do_pop, m_level);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();

        // Reset state, checked while reset is held and after release
        #1;
        check_outputs("in_reset");
        @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b0, "reset_idle");

        // Push three words, then drain them back to back
        step(1'b1, 4'h3, 1'b0, "push3");
        step(1'b1, 4'hA, 1'b0, "pushA");
        step(1'b1, 4'hF, 1'b0, "pushF");
        step(1'b0, 4'h0, 1'b1, "drain3");
        step(1'b0, 4'h0, 1'b1, "drainA");
        step(1'b0, 4'h0, 1'b1, "drainF");
        step(1'b0, 4'h0, 1'b0, "drained");

        // Fill to capacity, offer one word too many, then drain
        for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0, "fill");
        step(1'b1, 4'h9, 1'b0, "offer_full");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 4'h0, 1'b1, "drain_full");
        step(1'b0, 4'h0, 1'b0, "drained_full");

        // Streaming through the pointer wrap at a constant level of one
        step(1'b1, 4'h0, 1'b0, "stream_prime");
        for (int i = 1; i <= 20; i++) step(1'b1, DATA_W'(i % 16), 1'b1, "stream");
        step(1'b0, 4'h0, 1'b1, "stream_drain");
        step(1'b0, 4'h0, 1'b0, "stream_done");

        // Full buffer with a simultaneous offer and pop: only the pop happens
        for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(i + 5), 1'b0, "refill");
        step(1'b1, 4'hC, 1'b1, "full_push_pop");
        step(1'b1, 4'hD, 1'b0, "push_after_pop");
        step(1'b0, 4'h0, 1'b0, "full_again");

        // Reset asserted between edges must clear outputs immediately
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1, "to_level5");
        step(1'b0, 4'h0, 1'b0, "at_level5");
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs("mid_reset");
        @(posedge clk);
        #3 reset = 1'b0;
        step(1'b1, 4'h6, 1'b0, "push_after_reset");
        step(1'b0, 4'h0, 1'b0, "after_reset");
        step(1'b0, 4'h0, 1'b1, "final_drain");
        step(1'b0, 4'h0, 1'b0, "final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
